// File: rtl/mac_pkg.sv
// Shared types and helpers for the vector multiply-accumulate block.
// The saturating add works on wide sign-extended operands so one function serves every ACC_W.
package mac_pkg;

    localparam int LANES_DEF = 4;
    localparam int A_W_DEF   = 10;
    localparam int B_W_DEF   = 8;
    localparam int ACC_W_DEF = 32;
    localparam int CNT_W_DEF = 16;
    localparam int SUM_W     = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } mac_state_e;

    typedef struct packed {
        logic             ovf;
        logic [SUM_W-1:0] val;
    } sat_res_t;

    // Operands must already be sign-extended from acc_w; the wide sum cannot overflow itself.
    function automatic sat_res_t sat_add(input logic signed [SUM_W-1:0] a,
                                         input logic signed [SUM_W-1:0] b,
                                         input int acc_w,
                                         input logic sat);
        logic signed [SUM_W-1:0] sum;
        logic signed [SUM_W-1:0] max_v;
        logic signed [SUM_W-1:0] min_v;
        sat_res_t r;
        sum   = a + b;
        max_v = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        r.ovf = 1'b0;
        r.val = sum;
        if (sat) begin
            if (sum > max_v) begin
                r.ovf = 1'b1;
                r.val = max_v;
            end else if (sum < min_v) begin
                r.ovf = 1'b1;
                r.val = min_v;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_vec_lane.sv
// One MAC lane: product register (stage 1), accumulator and sticky saturation (stage 2).
// acc_nxt/sat_nxt expose the value the accumulator takes on a step so the top can capture results.
module mac_lane
    import mac_pkg::*;
#(
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic             init,
    input  logic [A_W-1:0]   src_0,
    input  logic [B_W-1:0]   src_1,
    output logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] acc_nxt,
    output logic             sat_nxt
);
    localparam int P_W = A_W + B_W + 1;

    logic signed [P_W-1:0]   prod_q;
    logic signed [SUM_W-1:0] base;
    logic signed [SUM_W-1:0] term;
    logic                    sat;
    sat_res_t                res;

    // An init beat sums onto zero, so an oversized first product still clamps or wraps.
    always_comb begin
        base    = init ? '0 : {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc};
        term    = {{(SUM_W-P_W){prod_q[P_W-1]}}, prod_q};
        res     = sat_add(base, term, ACC_W, SAT != 0);
        acc_nxt = res.val[ACC_W-1:0];
        sat_nxt = init ? res.ovf : (sat | res.ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            acc    <= '0;
            sat    <= 1'b0;
        end else begin
            if (load) begin
                prod_q <= $signed(src_0) * $signed({1'b0, src_1});
            end
            if (clear) begin
                acc <= '0;
                sat <= 1'b0;
            end else if (step) begin
                acc <= acc_nxt;
                sat <= sat_nxt;
            end
        end
    end

endmodule

// File: rtl/mac_vec.sv
// Vector MAC: two-stage lane pipeline, term counter, result holding register and control FSM.
// state | meaning: IDLE | no accumulation open; ACCUM | init seen, last not yet retired; HOLD | result waiting on out_rdy
module mac_vec
    import mac_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int SAT   = 1,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init,
    input  logic                   clear,
    input  logic                   src_vld,
    output logic                   src_rdy,
    input  logic                   last,
    input  logic [LANES*A_W-1:0]   src_0,
    input  logic [LANES*B_W-1:0]   src_1,
    output logic [LANES*B_W-1:0]   src_1_1d,
    output logic                   src_vld_1d,
    output logic [LANES*ACC_W-1:0] acc,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [LANES*ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0]       out_cnt,
    output logic [LANES-1:0]       out_sat
);
    logic                   en;
    logic                   accept;
    logic                   s1_vld;
    logic                   s1_init;
    logic                   s1_last;
    logic                   s2_fire;
    logic                   s2_last;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [LANES*ACC_W-1:0] acc_nxt;
    logic [LANES-1:0]       sat_nxt;
    mac_state_e             state;
    mac_state_e             state_nxt;
    mac_state_e             base_st;
    logic                   open_q;
    logic                   acc_open;

    assign en      = !(out_vld && !out_rdy);
    assign src_rdy = en;
    assign accept  = src_vld && en;
    assign s2_fire = s1_vld && en && !clear;
    assign s2_last = s2_fire && s1_last;
    assign cnt_nxt = s1_init ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(
            .A_W  (A_W),
            .B_W  (B_W),
            .ACC_W(ACC_W),
            .SAT  (SAT)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clear  (clear),
            .load   (accept),
            .step   (s2_fire),
            .init   (s1_init),
            .src_0  (src_0[i*A_W +: A_W]),
            .src_1  (src_1[i*B_W +: B_W]),
            .acc    (acc[i*ACC_W +: ACC_W]),
            .acc_nxt(acc_nxt[i*ACC_W +: ACC_W]),
            .sat_nxt(sat_nxt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld     <= 1'b0;
            s1_init    <= 1'b0;
            s1_last    <= 1'b0;
            src_1_1d   <= '0;
            src_vld_1d <= 1'b0;
        end else begin
            src_vld_1d <= accept;
            if (accept) begin
                src_1_1d <= src_1;
                s1_init  <= init;
                s1_last  <= last;
            end
            if (clear) begin
                s1_vld <= 1'b0;
            end else if (en) begin
                s1_vld <= accept;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            out_vld <= 1'b0;
            out_acc <= '0;
            out_cnt <= '0;
            out_sat <= '0;
        end else begin
            if (clear) begin
                cnt_q <= '0;
            end else if (s2_fire) begin
                cnt_q <= cnt_nxt;
            end
            if (s2_last) begin
                out_vld <= 1'b1;
                out_acc <= acc_nxt;
                out_cnt <= cnt_nxt;
                out_sat <= sat_nxt;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

    // open_q remembers whether an accumulation was open when HOLD was entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            open_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            open_q <= (base_st == ACCUM);
        end
    end

    always_comb begin
        base_st = acc_open ? ACCUM : IDLE;
        if (clear && state != HOLD) begin
            base_st = IDLE;
        end else if (s2_fire) begin
            if (s1_last) begin
                base_st = IDLE;
            end else if (s1_init) begin
                base_st = ACCUM;
            end
        end
        state_nxt = (out_vld && !out_rdy) ? HOLD : base_st;
    end

    always_comb begin
        acc_open = (state == ACCUM) || (state == HOLD && open_q);
    end

endmodule
